// File: rtl/conv4_window_scheduler.sv
// Window scheduler for the layer-4 3x3 conv engine: counts streamed pixels and releases
// each valid-convolution window once it is complete. Optional CONV4_STALL_CNT_EN adds stall_cycles.
module conv4_window_scheduler #(
    parameter int IMG_W = 12,
    parameter int IMG_H = 12,
    parameter int K     = 3,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          conv_start,
    input  logic          relu_3_ready,
    output logic          win_valid,
    input  logic          win_ready,
    output logic [3:0]    win_row,
    output logic [3:0]    win_col,
    output logic [AW-1:0] win_base,
    output logic          busy,
    output logic          done
`ifdef CONV4_STALL_CNT_EN
    ,
    output logic [15:0]   stall_cycles
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ISSUE,
        S_FINISH
    } state_t;

    localparam logic [AW-1:0] PIX_MAX  = AW'(IMG_W * IMG_H);
    localparam logic [AW-1:0] W_A      = AW'(IMG_W);
    localparam logic [AW-1:0] KM1_A    = AW'(K - 1);
    localparam logic [AW-1:0] ONE_A    = AW'(1);
    localparam logic [3:0]    COL_LAST = 4'(IMG_W - K);
    localparam logic [3:0]    ROW_LAST = 4'(IMG_H - K);

    state_t        state_q, state_d;
    logic [AW-1:0] pix_count_q, pix_count_d;
    logic [3:0]    win_row_q, win_row_d;
    logic [3:0]    win_col_q, win_col_d;
    logic [AW-1:0] win_base_q, win_base_d;
    logic          win_valid_q, win_valid_d;
    logic          avail_q, avail_d;

    logic [AW-1:0] need;
    logic          xfer;
    logic          last_win;
    logic          pix_inc;

    // Index of the bottom-right pixel of the current window; the window is complete
    // once the pixel count has moved strictly past it.
    assign need     = (AW'(win_row_q) + KM1_A) * W_A + AW'(win_col_q) + KM1_A;
    assign xfer     = win_valid_q && win_ready;
    assign last_win = (win_row_q == ROW_LAST) && (win_col_q == COL_LAST);
    assign pix_inc  = relu_3_ready && (pix_count_q != PIX_MAX)
                      && ((state_q == S_WAIT) || (state_q == S_ISSUE));

    always_comb begin
        state_d     = state_q;
        pix_count_d = pix_inc ? (pix_count_q + ONE_A) : pix_count_q;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
        win_base_d  = win_base_q;
        win_valid_d = 1'b0;
        avail_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (conv_start) begin
                    pix_count_d = '0;
                    win_row_d   = '0;
                    win_col_d   = '0;
                    win_base_d  = '0;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                // The compare result is registered first, giving a two-edge release latency.
                if (avail_q) begin
                    state_d     = S_ISSUE;
                    win_valid_d = 1'b1;
                end else begin
                    avail_d = (pix_count_q > need);
                end
            end
            S_ISSUE: begin
                win_valid_d = 1'b1;
                if (xfer) begin
                    win_valid_d = 1'b0;
                    if (last_win) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_WAIT;
                        if (win_col_q < COL_LAST) begin
                            win_col_d  = win_col_q + 4'd1;
                            win_base_d = win_base_q + ONE_A;
                        end else begin
                            win_col_d  = '0;
                            win_row_d  = win_row_q + 4'd1;
                            win_base_d = (AW'(win_row_q) + ONE_A) * W_A;
                        end
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pix_count_q <= '0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            win_base_q  <= '0;
            win_valid_q <= 1'b0;
            avail_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_count_q <= pix_count_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
            win_base_q  <= win_base_d;
            win_valid_q <= win_valid_d;
            avail_q     <= avail_d;
        end
    end

    assign win_valid = win_valid_q;
    assign win_row   = win_row_q;
    assign win_col   = win_col_q;
    assign win_base  = win_base_q;
    assign busy      = (state_q == S_WAIT) || (state_q == S_ISSUE);
    assign done      = (state_q == S_FINISH);

`ifdef CONV4_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    // Counts waiting-for-pixels cycles plus cycles where a presented window is refused.
    always_comb begin
        stall_d = stall_q;
        if ((state_q == S_IDLE) && conv_start) begin
            stall_d = '0;
        end else if (((state_q == S_WAIT) || ((state_q == S_ISSUE) && !win_ready))
                     && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule
